// File: rtl/sp_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_arb_pkg
//
// Shared definitions for the round-robin RAM arbiter.
//
// Contents:
//   NUM_PORTS_MAX  largest supported requester count (4)
//   PORT_IDX_W     width of a port index sized for NUM_PORTS_MAX
//   port_idx_t     port index type, used for the round-robin pointer and
//                  for the registered response select
//   rr_pick_t      result of a round-robin search: found flag + index
//   rr_pick()      round-robin search helper
// ---------------------------------------------------------------------------
package sp_ram_arb_pkg;

  localparam int NUM_PORTS_MAX = 4;
  localparam int PORT_IDX_W    = $clog2(NUM_PORTS_MAX);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic      found;
    port_idx_t idx;
  } rr_pick_t;

  // Returns the first requesting port at or after ptr, searching upward.
  // The search wraps modulo NUM_PORTS_MAX rather than the configured port
  // count. That visits the same ports in the same order as a modulo
  // NUM_PORTS search provided the caller zeroes the request bits above
  // NUM_PORTS-1 and ptr stays below NUM_PORTS: the extra candidates in the
  // wrap region can never request, so they are simply skipped.
  function automatic rr_pick_t rr_pick(input logic [NUM_PORTS_MAX-1:0] req,
                                       input port_idx_t                ptr);
    rr_pick_t  res;
    port_idx_t cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < NUM_PORTS_MAX; i++) begin
      cand = ptr + port_idx_t'(i);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_arb_ram.sv
// ---------------------------------------------------------------------------
// sp_ram
//
// Single-ported synchronous RAM with byte enables, read-before-write.
// A cycle with en=1 always returns the word stored at addr *before* any
// write in that same cycle takes effect; rdata holds its value while en=0.
// Contents are not reset.
//
// Parameters:
//   ADDR_WIDTH  byte-address width
//   DATA_WIDTH  word width, multiple of 8
//   NUM_WORDS   memory size in BYTES (historic name kept for compatibility
//               with existing instantiations)
//
// Ports:
//   clk    in   rising-edge clock
//   en     in   access enable
//   we     in   1 = write, 0 = read
//   addr   in   byte address; low log2(DATA_WIDTH/8) bits ignored
//   be     in   byte enables, used on writes only
//   wdata  in   write data
//   rdata  out  registered read data (old word on writes)
// ---------------------------------------------------------------------------
module sp_ram
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 65536
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int OFFSET_W       = $clog2(BYTES_PER_WORD);
  localparam int DEPTH          = NUM_WORDS / BYTES_PER_WORD;
  localparam int INDEX_W        = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [INDEX_W-1:0]    index;

  // Byte-offset bits (and any address bits above the RAM size) do not
  // select a word; folding them here keeps them visibly consumed.
  logic                  unused_addr_bits;

  assign index            = addr[OFFSET_W +: INDEX_W];
  assign unused_addr_bits = ^addr;

  // The read of mem[index] uses the pre-edge contents, so a write in the
  // same cycle returns the old word. Only enabled bytes are updated.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[index];
      if (we) begin
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
          if (be[b]) begin
            mem[index][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/sp_ram_arb.sv
// ---------------------------------------------------------------------------
// sp_ram_arb
//
// Round-robin arbiter sharing one sp_ram between NUM_PORTS requesters using
// the req/gnt/rvalid protocol. At most one access per cycle is granted and
// forwarded to the RAM; the response (read data, or the old word for a
// write) comes back one cycle later on the granted port's rvalid.
//
// Parameters:
//   NUM_PORTS   requester count, 2..4
//   ADDR_WIDTH  byte-address width on every port and on the RAM
//   DATA_WIDTH  data width, multiple of 8
//   RAM_BYTES   RAM size in bytes
//
// Ports (per-port fields are packed arrays indexed [NUM_PORTS-1:0]):
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   req_i     in   access request per port
//   addr_i    in   byte address per port
//   we_i      in   1 = write, 0 = read
//   be_i      in   byte enables (writes only)
//   wdata_i   in   write data
//   gnt_o     out  request accepted this cycle (combinational)
//   rvalid_o  out  response for the access granted in the previous cycle
//   rdata_o   out  RAM output broadcast to all ports; valid with rvalid_o[p]
// ---------------------------------------------------------------------------
module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_BYTES  = 65536
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]                    we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]                    gnt_o,
  output logic [NUM_PORTS-1:0]                    rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  // Round-robin pointer: the port searched first in the next cycle.
  port_idx_t                  rr_ptr;
  // Response tracking: an access was granted last cycle, and to whom.
  logic                       rvalid_q;
  port_idx_t                  rsel_q;

  logic [NUM_PORTS_MAX-1:0]   req_ext;
  rr_pick_t                   pick;

  logic                       ram_en;
  logic                       ram_we;
  logic [ADDR_WIDTH-1:0]      ram_addr;
  logic [BE_W-1:0]            ram_be;
  logic [DATA_WIDTH-1:0]      ram_wdata;
  logic [DATA_WIDTH-1:0]      ram_rdata;

  // Pick the winner, drive the RAM from it and decode the response.
  // Requests are zero-extended to the package maximum so rr_pick can search
  // a fixed-size vector. While rst_n is low no grant is issued, which also
  // keeps the RAM disabled so reset never disturbs its contents. With no
  // winner the RAM command fields are parked at zero; only en matters then.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_PORTS-1:0] = req_i;
    pick                   = rr_pick(req_ext, rr_ptr);

    gnt_o     = '0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_be    = '0;
    ram_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst_n && pick.found && (pick.idx == port_idx_t'(p))) begin
        gnt_o[p]  = 1'b1;
        ram_en    = 1'b1;
        ram_we    = we_i[p];
        ram_addr  = addr_i[p];
        ram_be    = be_i[p];
        ram_wdata = wdata_i[p];
      end
    end

    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = rvalid_q && (rsel_q == port_idx_t'(p));
      rdata_o[p]  = ram_rdata;
    end
  end

  // Advance the pointer past the winner (wrapping at NUM_PORTS-1) and
  // remember who was granted so the RAM output can be steered next cycle.
  // An idle cycle leaves the pointer where it was. Reset drops any
  // in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rvalid_q <= 1'b0;
      rsel_q   <= '0;
    end else begin
      rvalid_q <= pick.found;
      if (pick.found) begin
        rsel_q <= pick.idx;
        if (pick.idx == port_idx_t'(NUM_PORTS - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= pick.idx + port_idx_t'(1);
        end
      end
    end
  end

  sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (RAM_BYTES)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/sp_ram_arb.md
# sp_ram_arb

Round-robin arbiter that shares one `sp_ram` instance between `NUM_PORTS` requesters using the SoC req/gnt/rvalid memory protocol. It sits between the core's data port, the debug/loader port and the single-ported private RAM. It serialises at most one access per cycle onto the RAM and routes each response back to the port that was granted.

## Interface

- `NUM_PORTS`, 2: number of requesters; legal range 2..4.
- `ADDR_WIDTH`, 16: byte-address width on every port and on the RAM.
- `DATA_WIDTH`, 32: data width; multiple of 8.
- `RAM_BYTES`, 65536: RAM size in bytes; passed to `sp_ram.NUM_WORDS`, which counts bytes.

Ports (port `p` fields are arrays indexed `[NUM_PORTS-1:0]`):

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  **synchronous, active-low reset**.
- `req_i`  in  NUM_PORTS  access request per port.
- `addr_i`  in  NUM_PORTS x ADDR_WIDTH  byte address; the low `log2(DATA_WIDTH/8)` bits are ignored.
- `we_i`  in  NUM_PORTS  1 = write, 0 = read.
- `be_i`  in  NUM_PORTS x DATA_WIDTH/8  byte enables; only meaningful on writes.
- `wdata_i`  in  NUM_PORTS x DATA_WIDTH  write data.
- `gnt_o`  out  NUM_PORTS  request accepted this cycle; combinational.
- `rvalid_o`  out  NUM_PORTS  response for the access granted in the previous cycle.
- `rdata_o`  out  NUM_PORTS x DATA_WIDTH  read data; valid only with `rvalid_o[p]`.

## Operation

- **Arbitration**
  - Every cycle, at most one port is granted: the first requesting port at or after `rr_ptr`, searching upward modulo `NUM_PORTS`.
  - When nothing is requested, no grant is issued and `rr_ptr` is unchanged.
- **Pointer update**
  - On a grant to port `k`, `rr_ptr` becomes `(k+1) mod NUM_PORTS` at the next edge.
  - Two or more continuously requesting ports therefore alternate strictly. No port waits more than `NUM_PORTS-1` cycles once it is requesting.
- **RAM drive**
  - `en` = any grant.
  - `we`, `addr`, `be` and `wdata` are muxed from the granted port.
  - When nothing is granted, the mux select is don't-care and `en` = 0.
- **Response**
  - Registered `rvalid_q` and `rsel_q` capture "granted" and the granted index.
  - Next cycle: `rvalid_o[rsel_q]` = 1, all other `rvalid_o` = 0.
  - `rvalid` is returned for writes as well as reads.
- **rdata**
  - `rdata_o[p]` is the RAM output for every `p`, broadcast to all ports; ports sample it only on their own `rvalid`.
  - A write response carries the old word at that address, because the RAM is read-before-write. Requesters ignore it.
- **Requester rules**
  - Requesters hold `req`, `addr`, `we`, `be` and `wdata` stable until `gnt`.
  - The arbiter does not check these rules.
  - A port may drop `req` without having been granted; nothing is recorded for it.
- **Back-to-back access**
  - A granted port may request again in the very next cycle.
  - It then competes normally under round-robin, so there is no pipeline bubble when it is the only requester.

## Timing

- Grant latency: 0 cycles (`gnt_o` is combinational from `req_i` and `rr_ptr`).
- Response latency: exactly 1 cycle after `gnt`. One access is accepted per cycle, giving full throughput.
- Reset values while `rst_n` = 0, applied at the clock edge:
  - `rr_ptr` = 0, `rvalid_q` = 0, `rsel_q` = 0.
  - `gnt_o` is forced to 0 combinationally and RAM `en` = 0, so no RAM contents change.
  - Consequence: `rvalid_o` = 0 from the first edge with `rst_n` low.
  - `rdata_o` is not reset (RAM output).
- Reset mid-operation: an access granted in the cycle before the reset edge loses its `rvalid`. Requesters restart after reset.
- `rr_ptr` wraps from `NUM_PORTS-1` to 0.

## Structure

- Shared package `sp_ram_arb_pkg`:
  - `PORT_IDX_W = $clog2(NUM_PORTS_MAX)` with `NUM_PORTS_MAX = 4`.
  - Typedef `port_idx_t`.
  - Function `rr_pick(req, ptr)` returns the granted index and a found flag.
- One sub-module: `sp_ram`, instantiated directly inside with `ADDR_WIDTH`, `DATA_WIDTH` and `NUM_WORDS = RAM_BYTES`.
- The arbiter itself is one always_comb block (pick and mux) and one always_ff block (`rr_ptr`, `rvalid_q`, `rsel_q`).

## Test plan

- **Single port:** port 0 writes 0xDEADBEEF to 0x0010 with be=0xF, then reads 0x0010 → gnt in the same cycle for both; read `rvalid_o[0]` one cycle later with `rdata_o[0]` = 0xDEADBEEF.
- **Contention:** ports 0 and 1 request continuously from reset for 6 cycles → grants go 0,1,0,1,0,1; each `rvalid` follows its grant by one cycle, to the matching port only.
- **Byte enables:** write 0x11223344 to 0x0020, then port 1 writes 0xAAAAAAAA with be=0x5, then reads → 0x11AA33AA.
- **Read-during-write:** write 0x0 to 0x0030, then write 0x5555 to 0x0030 → the write's response rdata = 0x0; a subsequent read = 0x5555.
- **Reset mid-access:** grant port 1 a read in cycle N, assert `rst_n`=0 at edge N+1 → `rvalid_o` = 0 at N+1; after release, `rr_ptr` = 0, so simultaneous requests grant port 0 first.
- **Idle and withdrawn request:** port 1 raises `req` and drops it in the same cycle that port 0 is granted; then no requests for 3 cycles → no `rvalid` for port 1, RAM `en` = 0, `rr_ptr` unchanged during idle.
